// File: rtl/sequence_player_pkg.sv
// Shared game definitions for the sequence player: FSM encoding, colour-code width
// and the speed-to-step / tick-period mapping.
package sequence_player_pkg;

    localparam int unsigned CodeWidth = 2;
    localparam int unsigned LedWidth  = 1 << CodeWidth;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap,
        StFinish
    } state_e;

    // Speed 0 is treated as speed 1.
    function automatic int unsigned speed_to_step(input logic [1:0] speed);
        case (speed)
            2'd2:    return 2;
            2'd3:    return 4;
            default: return 1;
        endcase
    endfunction

    // Tick period in cycles: ceil(freq / step) + 1.
    function automatic int unsigned tick_period(input int unsigned freq, input logic [1:0] speed);
        int unsigned step;
        step = speed_to_step(speed);
        return (freq + step - 1) / step + 1;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Tick generator: after a start pulse, raises enable for one cycle every tick_period cycles.
module rate_divider
    import sequence_player_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] speed,
    output logic       enable
);

    logic [31:0] count_q, count_d;
    logic        running_q, running_d;
    logic [31:0] period;

    assign period = tick_period(CLOCK_FREQUENCY, speed);

    // Count runs 1..period; the first enable lands period cycles after start is sampled.
    always_comb begin
        enable    = running_q && (count_q == period);
        count_d   = count_q;
        running_d = running_q;
        if (start) begin
            count_d   = 32'd1;
            running_d = 1'b1;
        end else if (running_q) begin
            count_d = enable ? 32'd1 : count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= 32'd0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/sequence_player.sv
// Plays a latched sequence of colour codes on a one-hot LED display, alternating
// SHOW and GAP phases paced by the rate divider.
module sequence_player
    import sequence_player_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned MAX_LEN         = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          play,
    input  logic [1:0]                    speed,
    input  logic [4:0]                    length,
    input  logic [CodeWidth*MAX_LEN-1:0]  seq_data,
    output logic [LedWidth-1:0]           led,
    output logic [3:0]                    index,
    output logic                          busy,
    output logic                          done
);

    localparam logic [4:0] MaxLength = 5'(MAX_LEN);

    state_e                         state_q, state_d;
    logic [4:0]                     len_q;
    logic [CodeWidth*MAX_LEN-1:0]   data_q;
    logic [1:0]                     speed_q;
    logic [3:0]                     index_q, index_d;
    logic [LedWidth-1:0]            led_q, led_d;
    logic                           busy_q, done_q;

    logic                           accept;
    logic                           tick;
    logic [4:0]                     length_clamped;
    logic [3:0]                     last_index;
    logic [CodeWidth*MAX_LEN-1:0]   data_src;
    logic [CodeWidth-1:0]           codes [MAX_LEN];

    assign accept         = (state_q == StIdle) && play;
    assign length_clamped = (length > MaxLength) ? MaxLength : length;
    assign last_index     = 4'(len_q - 5'd1);
    // The first step is lit on the accepting edge, before the latch holds the new data.
    assign data_src       = accept ? seq_data : data_q;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            codes[i] = data_src[CodeWidth*i +: CodeWidth];
        end
    end

    rate_divider #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_rate_divider (
        .clock  (clock),
        .reset  (reset),
        .start  (accept),
        .speed  (speed_q),
        .enable (tick)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            StIdle: begin
                if (play) begin
                    index_d = 4'd0;
                    state_d = (length_clamped == 5'd0) ? StFinish : StShow;
                end
            end
            StShow: begin
                if (tick) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (tick) begin
                    if (index_q == last_index) begin
                        state_d = StFinish;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = StShow;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        led_d = '0;
        if (state_d == StShow) begin
            led_d = LedWidth'(1) << codes[index_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= 4'd0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            led_q   <= led_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_q == StFinish);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            len_q   <= length_clamped;
            data_q  <= seq_data;
            speed_q <= (speed == 2'd0) ? 2'd1 : speed;
        end
    end

    assign led   = led_q;
    assign index = index_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player at CLOCK_FREQUENCY=8 (P=9 at speed 1, P=5 at speed 2).
module tb_sequence_player;

    localparam int unsigned ClockFrequency = 8;
    localparam int unsigned MaxLen         = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  speed;
    logic [4:0]  length;
    logic [31:0] seq_data;
    logic [3:0]  led;
    logic [3:0]  index;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;

    sequence_player #(
        .CLOCK_FREQUENCY(ClockFrequency),
        .MAX_LEN        (MaxLen)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .play     (play),
        .speed    (speed),
        .length   (length),
        .seq_data (seq_data),
        .led      (led),
        .index    (index),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulse_play();
        @(posedge clock);
        #1 play = 1'b1;
        @(posedge clock);
        #1 play = 1'b0;
    endtask

    // n cycles of a playing phase: led/index fixed, busy high, no done.
    task automatic check_phase(input string tag, input logic [3:0] exp_led,
                               input logic [3:0] exp_idx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check({tag, "_led"}, 32'(led), 32'(exp_led));
            check({tag, "_index"}, 32'(index), 32'(exp_idx));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done"}, 32'(done), 32'd0);
            if (busy === 1'b1) busy_seen++;
        end
    endtask

    // FINISH cycle, then the done cycle with busy low, then done cleared.
    task automatic check_finish(input string tag);
        @(negedge clock);
        check({tag, "_fin_busy"}, 32'(busy), 32'd1);
        check({tag, "_fin_done"}, 32'(done), 32'd0);
        check({tag, "_fin_led"}, 32'(led), 32'd0);
        if (busy === 1'b1) busy_seen++;
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_led"}, 32'(led), 32'd0);
        if (busy === 1'b1) busy_seen++;
        @(negedge clock);
        check({tag, "_done_clear"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        play     = 1'b0;
        speed    = 2'd1;
        length   = 5'd0;
        seq_data = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst_led", 32'(led), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Steps 2,0,3 at speed 1.
        length   = 5'd3;
        seq_data = 32'h0000_0032;
        speed    = 2'd1;
        pulse_play();
        check_phase("t1_s0", 4'b0100, 4'd0, 9);
        check_phase("t1_g0", 4'b0000, 4'd0, 9);
        check_phase("t1_s1", 4'b0001, 4'd1, 9);
        check_phase("t1_g1", 4'b0000, 4'd1, 9);
        check_phase("t1_s2", 4'b1000, 4'd2, 9);
        check_phase("t1_g2", 4'b0000, 4'd2, 9);
        check_finish("t1");

        // Speed 2, one step of code 1; speed input changed mid-run has no effect.
        length    = 5'd1;
        seq_data  = 32'h0000_0001;
        speed     = 2'd2;
        busy_seen = 0;
        pulse_play();
        speed = 2'd3;
        check_phase("t2_s0", 4'b0010, 4'd0, 5);
        check_phase("t2_g0", 4'b0000, 4'd0, 5);
        check_finish("t2");
        check("t2_busy_total", 32'(busy_seen), 32'd11);

        // Length 0: done two cycles after play, led never lit.
        length = 5'd0;
        speed  = 2'd1;
        pulse_play();
        @(negedge clock);
        check("t3_c0_busy", 32'(busy), 32'd1);
        check("t3_c0_done", 32'(done), 32'd0);
        check("t3_c0_led", 32'(led), 32'd0);
        @(negedge clock);
        check("t3_c1_done", 32'(done), 32'd1);
        check("t3_c1_busy", 32'(busy), 32'd0);
        check("t3_c1_led", 32'(led), 32'd0);
        @(negedge clock);
        check("t3_c2_done", 32'(done), 32'd0);

        // Length 4, codes 0,1,2,3 at speed 2; play re-pulsed with new inputs during step 1.
        length   = 5'd4;
        seq_data = 32'h0000_00E4;
        speed    = 2'd2;
        pulse_play();
        check_phase("t4_s0", 4'b0001, 4'd0, 5);
        check_phase("t4_g0", 4'b0000, 4'd0, 5);
        check_phase("t4_s1a", 4'b0010, 4'd1, 2);
        play     = 1'b1;
        length   = 5'd1;
        seq_data = 32'h0000_0000;
        speed    = 2'd1;
        check_phase("t4_s1b", 4'b0010, 4'd1, 1);
        play = 1'b0;
        check_phase("t4_s1c", 4'b0010, 4'd1, 2);
        check_phase("t4_g1", 4'b0000, 4'd1, 5);
        check_phase("t4_s2", 4'b0100, 4'd2, 5);
        check_phase("t4_g2", 4'b0000, 4'd2, 5);
        check_phase("t4_s3", 4'b1000, 4'd3, 5);
        check_phase("t4_g3", 4'b0000, 4'd3, 5);
        check_finish("t4");

        // Reset during the gap of step 2, then a clean restart.
        length   = 5'd4;
        seq_data = 32'h0000_00E4;
        speed    = 2'd2;
        pulse_play();
        check_phase("t5_s0", 4'b0001, 4'd0, 5);
        check_phase("t5_g0", 4'b0000, 4'd0, 5);
        check_phase("t5_s1", 4'b0010, 4'd1, 5);
        check_phase("t5_g1", 4'b0000, 4'd1, 5);
        check_phase("t5_s2", 4'b0100, 4'd2, 5);
        check_phase("t5_g2", 4'b0000, 4'd2, 2);
        reset = 1'b1;
        @(negedge clock);
        check("t5_rst_led", 32'(led), 32'd0);
        check("t5_rst_index", 32'(index), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("t5_quiet_done", 32'(done), 32'd0);
            check("t5_quiet_busy", 32'(busy), 32'd0);
        end
        pulse_play();
        check_phase("t5_r_s0", 4'b0001, 4'd0, 5);
        check_phase("t5_r_g0", 4'b0000, 4'd0, 5);
        check_phase("t5_r_s1", 4'b0010, 4'd1, 1);

        // Reset and play in the same cycle: reset wins.
        @(negedge clock);
        reset = 1'b1;
        play  = 1'b1;
        @(negedge clock);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_led", 32'(led), 32'd0);
        reset = 1'b0;
        play  = 1'b0;
        @(negedge clock);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("t6_done_after", 32'(done), 32'd0);

        // Length 20 clamps to 16, speed 0 plays as speed 1.
        length   = 5'd20;
        seq_data = 32'hE4E4_E4E4;
        speed    = 2'd0;
        pulse_play();
        for (int i = 0; i < 16; i++) begin
            check_phase($sformatf("t7_s%0d", i), 4'(4'b0001 << (i % 4)), 4'(i), 9);
            check_phase($sformatf("t7_g%0d", i), 4'b0000, 4'(i), 9);
        end
        check_finish("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, meaning clock cycles per 1 s at speed 1.
REQ-002 SHALL have parameter MAX_LEN, default 16, meaning maximum sequence steps.
REQ-003 SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port play, input, 1, a start-playback pulse.
REQ-006 SHALL have port speed, input, 2: 1 = 1 s, 2 = 0.5 s, 3 = 0.25 s per phase; 0 is treated as 1.
REQ-007 SHALL have port length, input, 5, the number of steps to play.
REQ-008 SHALL have port seq_data, input, 2*MAX_LEN, packed colour codes; step i is seq_data[2i+1:2i].
REQ-009 SHALL have port led, output, 4, one-hot colour display; 0 = all off.
REQ-010 SHALL have port index, output, 4, the step currently shown.
REQ-011 SHALL have port busy, output, 1, high whenever not IDLE.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at playback end.

Function
REQ-013 SHALL implement FSM states IDLE, SHOW, GAP, FINISH.
REQ-014 SHALL, in IDLE on play=1, latch length, seq_data and speed (0 mapped to 1), clear index, issue a one-cycle tick-generator start, and go to SHOW next cycle.
REQ-015 SHALL clamp a latched length > MAX_LEN to MAX_LEN; a latched length of 0 SHALL go from IDLE directly to FINISH with led never lit.
REQ-016 SHALL, in SHOW, register led = one-hot of the latched step code, with code c lighting bit c.
REQ-017 SHALL, on a tick in SHOW, go to GAP with led = 0.
REQ-018 SHALL, on a tick in GAP, go to FINISH if index = length-1; otherwise increment index and go to SHOW.
REQ-019 SHALL, in FINISH, assert done for exactly one cycle and return to IDLE; busy is low in that next IDLE cycle.
REQ-020 SHALL ignore play while busy=1; latched values SHALL NOT change until the next IDLE-accepted play.
REQ-021 SHALL ignore ticks in IDLE and FINISH.
REQ-022 SHALL define tick period P as ceil(CLOCK_FREQUENCY/step)+1 cycles, with step = 1, 2 or 4 for speed 1, 2 or 3.
REQ-023 SHALL place the first tick P cycles after the start pulse, with each further tick every P cycles; each SHOW and GAP phase therefore lasts exactly P cycles.
REQ-024 SHALL change led, index, busy and done only on clock edges (registered outputs).
REQ-025 SHALL let input speed changes during playback have no effect on timing.
REQ-026 SHALL handle play and reset asserted in the same cycle as reset wins.

Reset
REQ-027 SHALL, on reset=1, set the state to IDLE, led=0, index=0, busy=0, done=0 at the next edge, including mid-playback.
REQ-028 SHALL also hold the tick generator idle under reset, with no stale tick reaching a new playback.
REQ-029 SHALL require no reset values for the latched length, seq_data and speed registers.

Structure
REQ-030 SHALL put the state encoding, the speed-to-step mapping and the colour-code width in a shared game package.
REQ-031 SHALL use a single sub-module, rate_divider (inputs clock, reset, start, speed; output enable), as the tick generator.
REQ-032 SHALL drive rate_divider from the latched speed.
REQ-033 SHALL contain no other sub-modules.

Verification (CLOCK_FREQUENCY=8, so P=9 at speed 1 and P=5 at speed 2)
REQ-034 SHALL cover: length=3, steps 2,0,3, speed=1, play -> led 0100 for 9 cycles, 0 for 9, 0001 for 9, 0 for 9, 1000 for 9, 0 for 9, then done for 1 cycle and busy low.
REQ-035 SHALL cover: speed=2, length=1, code 1 -> led 0010 for 5 cycles, 0 for 5, then done; total busy = 11 cycles.
REQ-036 SHALL cover: length=0, play -> done pulses 2 cycles after play, led stays 0.
REQ-037 SHALL cover: play re-pulsed at step 1 of a length-4 run -> playback unaffected and done after 4 steps.
REQ-038 SHALL cover: reset asserted during GAP of step 2 -> next edge led=0, index=0, busy=0, no done pulse, and a subsequent play restarts at step 0 with a full P-cycle first phase.
REQ-039 SHALL cover: length=20, speed=0 -> 16 steps played at P=9, done after step 15.
